// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall/flush and write-back refresh of held operands.
// Define ID_EX_FORWARD_EN to add EX/MEM and MEM/WB operand forwarding muxes on the outputs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [2:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_addr,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rd_addr
);

    logic              v_q, v_d;
    logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [2:0]        op_q, op_d;
    logic              src_q, src_d;
    logic              wr_q, wr_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    always_comb begin
        v_d       = v_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        op_d      = op_q;
        src_d     = src_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (flush) begin
            v_d       = 1'b0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rs_d      = '0;
            rt_d      = '0;
            imm_d     = '0;
            op_d      = 3'b000;
            src_d     = 1'b0;
            wr_d      = 1'b0;
            rd_d      = '0;
        end else if (stall) begin
            // A producer may retire during a long stall; pick its result up now.
            if (wb_we && (wb_addr != '0) && (wb_addr == rs_addr_q)) rs_d = wb_data;
            if (wb_we && (wb_addr != '0) && (wb_addr == rt_addr_q)) rt_d = wb_data;
        end else begin
            v_d       = id_valid;
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rs_d      = id_rs_data;
            rt_d      = id_rt_data;
            imm_d     = id_imm;
            op_d      = id_alu_op;
            src_d     = id_alu_src;
            wr_d      = id_reg_write;
            rd_d      = id_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            op_q      <= 3'b000;
            src_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= '0;
        end else begin
            v_q       <= v_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            op_q      <= op_d;
            src_q     <= src_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    // Operand 0 is rs, operand 1 is rt.
    logic [REG_AW-1:0] opnd_addr [2];
    logic [DATA_W-1:0] opnd_reg  [2];
    logic [DATA_W-1:0] opnd_fwd  [2];

    assign opnd_addr[0] = rs_addr_q;
    assign opnd_addr[1] = rt_addr_q;
    assign opnd_reg[0]  = rs_q;
    assign opnd_reg[1]  = rt_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef ID_EX_FORWARD_EN
            always_comb begin
                opnd_fwd[gi] = opnd_reg[gi];
                if (opnd_addr[gi] != '0) begin
                    if (exm_we && (exm_addr == opnd_addr[gi]))
                        opnd_fwd[gi] = exm_data;
                    else if (wb_we && (wb_addr == opnd_addr[gi]))
                        opnd_fwd[gi] = wb_data;
                end
            end
`else
            assign opnd_fwd[gi] = opnd_reg[gi];
`endif
        end
    endgenerate

`ifndef ID_EX_FORWARD_EN
    // Without forwarding the EX/MEM port has no consumer; hazards are stalled upstream.
    logic unused_exm;
    assign unused_exm = ^{exm_we, exm_addr, exm_data};
`endif

    assign alu_a         = opnd_fwd[0];
    assign alu_b         = src_q ? imm_q : opnd_fwd[1];
    assign ex_store_data = opnd_fwd[1];
    assign alu_op        = v_q ? op_q : 3'b000;
    assign ex_valid      = v_q;
    assign ex_reg_write  = v_q & wr_q;
    assign ex_rd_addr    = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; forwarding expectations follow whether ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, stall, flush, id_valid, id_alu_src, id_reg_write;
    logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr, exm_addr, wb_addr;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, exm_data, wb_data;
    logic [2:0]    id_alu_op;
    logic          exm_we, wb_we;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [2:0]    alu_op;
    logic          ex_valid, ex_reg_write;
    logic [AW-1:0] ex_rd_addr;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_rd_addr(id_rd_addr), .exm_we(exm_we), .exm_addr(exm_addr),
        .exm_data(exm_data), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s observed %h expected %h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [AW-1:0] ra, input logic [DW-1:0] rd_a,
                        input logic [AW-1:0] ta, input logic [DW-1:0] td,
                        input logic [DW-1:0] imm, input logic [2:0] op, input logic src,
                        input logic wr, input logic [AW-1:0] rd);
        id_valid = v; id_rs_addr = ra; id_rs_data = rd_a; id_rt_addr = ta; id_rt_data = td;
        id_imm = imm; id_alu_op = op; id_alu_src = src; id_reg_write = wr; id_rd_addr = rd;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        exm_we = 1'b0; exm_addr = '0; exm_data = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        load(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 5'd0);
        tick(); tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_aluop", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain load: SUB 5 - 3
        load(1'b1, 5'd1, 32'h5, 5'd2, 32'h3, 32'h0, 3'b100, 1'b0, 1'b1, 5'd9);
        tick();
        chk("ld_alu_a", alu_a, 32'h5);
        chk("ld_alu_b", alu_b, 32'h3);
        chk("ld_aluop", {29'd0, alu_op}, 32'h4);
        chk("ld_store", ex_store_data, 32'h3);
        chk("ld_valid", {31'd0, ex_valid}, 32'd1);
        chk("ld_regwr", {31'd0, ex_reg_write}, 32'd1);
        chk("ld_rd", {27'd0, ex_rd_addr}, 32'd9);

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_aluop", {29'd0, alu_op}, 32'd0);
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_regwr", {31'd0, ex_reg_write}, 32'd0);
        chk("arst_rd", {27'd0, ex_rd_addr}, 32'd0);
        chk("arst_store", ex_store_data, 32'd0);
        #2 rst_n = 1'b1;

        // Forwarding priority on rs, then rt
        load(1'b1, 5'd4, 32'h10, 5'd5, 32'h20, 32'h0, 3'b000, 1'b0, 1'b1, 5'd6);
        tick();
        exm_we = 1'b1; exm_addr = 5'd4; exm_data = 32'hAAAA_0000;
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111;
        #1;
        chk("fwd_exm_pri", alu_a, FWD ? 32'hAAAA_0000 : 32'h10);
        exm_we = 1'b0;
        #1;
        chk("fwd_wb", alu_a, FWD ? 32'h1111 : 32'h10);
        wb_we = 1'b0; exm_we = 1'b1; exm_addr = 5'd5; exm_data = 32'hBEEF;
        #1;
        chk("fwd_rt_store", ex_store_data, FWD ? 32'hBEEF : 32'h20);
        chk("fwd_rt_alub", alu_b, FWD ? 32'hBEEF : 32'h20);
        exm_we = 1'b0;

        // Address 0 is never forwarded
        load(1'b1, 5'd0, 32'h77, 5'd0, 32'h88, 32'h0, 3'b001, 1'b0, 1'b1, 5'd1);
        tick();
        exm_we = 1'b1; exm_addr = 5'd0; exm_data = 32'hDEAD;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hCAFE;
        #1;
        chk("fwd_zero_rs", alu_a, 32'h77);
        chk("fwd_zero_rt", ex_store_data, 32'h88);
        exm_we = 1'b0; wb_we = 1'b0;

        // Three-cycle stall with write-back refresh of rt in the second cycle
        load(1'b1, 5'd6, 32'h66, 5'd7, 32'h70, 32'h5, 3'b001, 1'b0, 1'b1, 5'd3);
        tick();
        stall = 1'b1;
        load(1'b1, 5'd9, 32'hFFFF, 5'd10, 32'hEEEE, 32'h9, 3'b010, 1'b1, 1'b0, 5'd12);
        tick();
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        tick();
        chk("stall_rt", ex_store_data, 32'h1234);
        chk("stall_alu_b", alu_b, 32'h1234);
        chk("stall_rs", alu_a, 32'h66);
        chk("stall_aluop", {29'd0, alu_op}, 32'h1);
        chk("stall_rd", {27'd0, ex_rd_addr}, 32'd3);
        chk("stall_regwr", {31'd0, ex_reg_write}, 32'd1);

        // Refresh to register 0 must be ignored even if rt_addr_q were 0
        load(1'b1, 5'd0, 32'h31, 5'd0, 32'h32, 32'h0, 3'b000, 1'b0, 1'b1, 5'd2);
        stall = 1'b0;
        tick();
        stall = 1'b1; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555;
        tick();
        wb_we = 1'b0;
        #1;
        chk("refresh_zero", ex_store_data, 32'h32);

        // Flush beats stall
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_regwr", {31'd0, ex_reg_write}, 32'd0);
        chk("flush_aluop", {29'd0, alu_op}, 32'd0);
        chk("flush_alu_a", alu_a, 32'd0);

        // LUI with immediate B, rt forwarding must not reach alu_b
        load(1'b1, 5'd1, 32'h1, 5'd8, 32'h99, 32'h0000_ABCD, 3'b110, 1'b1, 1'b1, 5'd4);
        tick();
        exm_we = 1'b1; exm_addr = 5'd8; exm_data = 32'hDEAD;
        #1;
        chk("lui_alu_b", alu_b, 32'h0000_ABCD);
        chk("lui_aluop", {29'd0, alu_op}, 32'h6);
        chk("lui_store", ex_store_data, FWD ? 32'hDEAD : 32'h99);
        exm_we = 1'b0;

        // Bubble from decode: reg_write captured but masked
        load(1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 3'b101, 1'b0, 1'b1, 5'd7);
        tick();
        chk("bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("bub_regwr", {31'd0, ex_reg_write}, 32'd0);
        chk("bub_aluop", {29'd0, alu_op}, 32'd0);
        chk("bub_rd", {27'd0, ex_rd_addr}, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
